// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall controller:
//   - StallBus type and per-stage bit positions (PC, IF, ID, EX, MEM, WB)
//   - Stop / NoStop hold levels
//   - Canonical stall patterns (none, load-use, divide)
//   - Controller state encoding
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int unsigned STALL_BUS_W = 6;

  typedef logic [STALL_BUS_W-1:0] StallBus;

  // Bit positions within StallBus
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Load-use: PC/IF/ID hold, a bubble flows into EX.
  // Divide:   PC/IF/ID/EX hold, MEM/WB drain.
  localparam StallBus STALL_NONE    = 6'b000000;
  localparam StallBus STALL_LOADUSE = 6'b000111;
  localparam StallBus STALL_DIV     = 6'b001111;

  typedef enum logic [1:0] {
    PC_IDLE     = 2'd0,
    PC_DIV_WAIT = 2'd1,
    PC_DIV_DONE = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low clear
//   i_inc    - increment enable for this cycle
//   o_cnt    - current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == {W{1'b1}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline stall controller and iterative-divider sequencer. Sole
// driver of the stall bus seen by PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Ports:
//   i_clk              - clock, rising edge
//   i_rst_n            - asynchronous active-low reset (also resets divider)
//   i_stallreq_from_id - load-use hazard detected in ID
//   i_div_req          - div/divu in EX, held until it leaves EX
//   i_div_done         - divider result valid (one-cycle pulse)
//   o_stall            - per-stage hold, 1 = Stop
//   o_div_start        - one-cycle divider launch
//   o_div_busy         - waiting on the divider
//   o_div_result_ok    - EX may latch quotient/remainder this cycle
//   o_div_timeout      - one-cycle pulse when the wait expires
//   o_stall_cnt        - saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W     = STALL_BUS_W,
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stallreq_from_id,
  input  logic               i_div_req,
  input  logic               i_div_done,
  output logic [STALL_W-1:0] o_stall,
  output logic               o_div_start,
  output logic               o_div_busy,
  output logic               o_div_result_ok,
  output logic               o_div_timeout,
  output logic [CNT_W-1:0]   o_stall_cnt
);

  localparam int unsigned WAIT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV_TIMEOUT - 1);

  pc_state_e         r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;

  StallBus w_stall;
  logic    w_div_start;
  logic    w_div_result_ok;
  logic    w_div_timeout;
  logic    w_stall_any;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= PC_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_stall         = STALL_NONE;
    w_div_start     = 1'b0;
    w_div_result_ok = 1'b0;
    w_div_timeout   = 1'b0;

    unique case (r_state)
      PC_IDLE: begin
        if (i_div_req) begin
          w_stall        = STALL_DIV;
          w_div_start    = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = PC_DIV_WAIT;
        end else if (i_stallreq_from_id) begin
          w_stall = STALL_LOADUSE;
        end
      end

      PC_DIV_WAIT: begin
        // The divide stall already freezes ID, so a load-use request needs no action.
        w_stall = STALL_DIV;
        if (i_div_done) begin
          w_state_nxt = PC_DIV_DONE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_div_timeout = 1'b1;
          w_state_nxt   = PC_DIV_DONE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end

      PC_DIV_DONE: begin
        // div_req is still asserted by the departing instruction; ignore it here.
        w_div_result_ok = 1'b1;
        w_stall         = i_stallreq_from_id ? STALL_LOADUSE : STALL_NONE;
        w_state_nxt     = PC_IDLE;
      end

      default: begin
        w_state_nxt = PC_IDLE;
      end
    endcase
  end

  assign o_stall         = w_stall;
  assign o_div_start     = w_div_start;
  assign o_div_busy      = (r_state == PC_DIV_WAIT);
  assign o_div_result_ok = w_div_result_ok;
  assign o_div_timeout   = w_div_timeout;

  // ---------------------------------------------------------------------------
  // Stall performance counter
  // ---------------------------------------------------------------------------
  assign w_stall_any = (w_stall != STALL_NONE);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_stall_any),
    .o_cnt   (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed scenarios plus randomized traffic against a transaction-level model
// of the stall controller. A small counter width exercises saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int TO    = 40;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b000111;
  localparam logic [5:0] S_DIV  = 6'b001111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stallreq;
  logic          div_req;
  logic          div_done;
  logic [5:0]    stall;
  logic          div_start;
  logic          div_busy;
  logic          div_result_ok;
  logic          div_timeout;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a divide is "in flight" from the cycle after launch until the
  // divider answers or the budget is spent; the following cycle releases EX.
  bit m_in_flight;
  int m_waited;
  bit m_release;
  int m_stalled;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .DIV_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_stallreq_from_id (stallreq),
    .i_div_req          (div_req),
    .i_div_done         (div_done),
    .o_stall            (stall),
    .o_div_start        (div_start),
    .o_div_busy         (div_busy),
    .o_div_result_ok    (div_result_ok),
    .o_div_timeout      (div_timeout),
    .o_stall_cnt        (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_in_flight = 0;
    m_waited    = 0;
    m_release   = 0;
    m_stalled   = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input bit lu, input bit dr, input bit dd);
    logic [5:0] e_stall;
    bit e_start, e_busy, e_ok, e_to;
    @(negedge clk);
    stallreq = lu;
    div_req  = dr;
    div_done = dd;
    #1;
    e_stall = S_NONE;
    e_start = 0; e_busy = 0; e_ok = 0; e_to = 0;
    check("stall_cnt", stall_cnt, m_stalled);
    if (m_in_flight) begin
      e_stall = S_DIV;
      e_busy  = 1;
      if (dd) begin
        m_in_flight = 0;
        m_release   = 1;
      end else if (m_waited + 1 == TO) begin
        e_to        = 1;
        m_in_flight = 0;
        m_release   = 1;
      end else begin
        m_waited++;
      end
    end else if (m_release) begin
      e_ok      = 1;
      e_stall   = lu ? S_LU : S_NONE;
      m_release = 0;
    end else if (dr) begin
      e_stall     = S_DIV;
      e_start     = 1;
      m_in_flight = 1;
      m_waited    = 0;
    end else if (lu) begin
      e_stall = S_LU;
    end
    check("stall", stall, e_stall);
    check("div_start", div_start, e_start);
    check("div_busy", div_busy, e_busy);
    check("div_result_ok", div_result_ok, e_ok);
    check("div_timeout", div_timeout, e_to);
    if (e_stall != S_NONE && m_stalled < CMAX) m_stalled++;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_stall"}, stall, S_NONE);
    check({tag, "_start"}, div_start, 1'b0);
    check({tag, "_busy"}, div_busy, 1'b0);
    check({tag, "_ok"}, div_result_ok, 1'b0);
    check({tag, "_to"}, div_timeout, 1'b0);
    check({tag, "_cnt"}, stall_cnt, 0);
  endtask

  int hold;
  int done_at;
  bit no_done;

  initial begin
    rst_n = 1'b0; stallreq = 1'b0; div_req = 1'b0; div_done = 1'b0;
    model_clear();
    #23;
    reset_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);

    // Single load-use cycle
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("lu_cnt", stall_cnt, 1);

    // Divide answered 5 cycles after launch: EX held 6 cycles
    hold = 0;
    for (int i = 0; i <= 5; i++) begin
      cycle(0, 1, (i == 5));
      if (stall[3]) hold++;
    end
    cycle(0, 1, 0);
    check("div5_ok", div_result_ok, 1'b1);
    check("div5_rel", stall, S_NONE);
    cycle(0, 0, 0);
    check("div5_hold", hold, 6);

    // Timeout: launch + 40 wait cycles, then release
    hold = 0;
    for (int i = 0; i < 41; i++) begin
      cycle(0, 1, 0);
      if (stall[3]) hold++;
      if (i == 40) check("to_pulse", div_timeout, 1'b1);
    end
    cycle(0, 1, 0);
    check("to_ok", div_result_ok, 1'b1);
    check("to_hold", hold, 41);

    // Back-to-back: next divide restarts right after release
    cycle(1, 1, 0);
    check("b2b_start", div_start, 1'b1);
    check("both_stall", stall, S_DIV);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    cycle(1, 1, 0);
    check("done_lu_stall", stall, S_LU);
    check("done_lu_ok", div_result_ok, 1'b1);
    cycle(0, 0, 0);

    // done coinciding with the last allowed wait cycle: no timeout pulse
    cycle(0, 1, 0);
    for (int i = 0; i < TO; i++) begin
      cycle(0, 1, (i == TO - 1));
      if (i == TO - 1) check("done_wins_to", div_timeout, 1'b0);
    end
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Reset in the 3rd DIV_WAIT cycle
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0; stallreq = 1'b0; div_req = 1'b0; div_done = 1'b0;
    #1;
    model_clear();
    reset_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 0);
    check("relaunch", div_start, 1'b1);

    // Randomized traffic
    no_done = 0;
    done_at = 0;
    for (int i = 0; i < 3000; i++) begin
      bit lu, dr, dd;
      lu = ($urandom_range(0, 3) == 0);
      if (m_in_flight || m_release) begin
        dr = 1;
        dd = no_done ? 1'b0 : ($urandom_range(0, 5) == 0);
      end else begin
        dr = ($urandom_range(0, 4) == 0);
        dd = ($urandom_range(0, 15) == 0);
        if (dr) no_done = ($urandom_range(0, 7) == 0);
      end
      cycle(lu, dr, dd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
